// File: rtl/integral_image_builder.sv
// ---------------------------------------------------------------------------
// integral_image_builder
//
// Writer side of the integral image memory. Consumes a raster-order pixel
// stream and emits one integral-image word per accepted pixel, row-major
// from address 0. The value written for pixel (c,r) is the sum of all
// pixels above and to the left of it, inclusive.
//
// The sum is formed as (running sum of the current row) plus (integral value
// of the same column one row above). The second term comes from an internal
// one-row shift-register line buffer, so the RAM is never read back.
//
// Ports
//   clk_vga     in   single clock, rising edge
//   rst         in   synchronous, active-high reset
//   pix_valid   in   pixel present this cycle (no backpressure)
//   pix_sof     in   first pixel of a frame (qualified by pix_valid)
//   pix_data    in   PIX_W-bit unsigned intensity
//   wr_en       out  RAM write strobe (one cycle after pixel acceptance)
//   wr_addr     out  15-bit RAM address, row*II_WIDTH+col
//   wr_data     out  20-bit integral value
//   busy        out  high while a frame is being accumulated
//   frame_done  out  pulse coincident with the final write of a frame
//   frame_err   out  sticky flag: sof seen while a frame was in progress
//
// Build option
//   II_BUILDER_ERR_EN  when defined, frame_err is implemented; otherwise it
//                      is tied low. Restart-on-sof behaviour is identical
//                      in both builds.
// ---------------------------------------------------------------------------
module integral_image_builder #(
    parameter int II_WIDTH  = 160,
    parameter int II_HEIGHT = 120,
    parameter int PIX_W     = 4
) (
    input  logic              clk_vga,
    input  logic              rst,
    input  logic              pix_valid,
    input  logic              pix_sof,
    input  logic [PIX_W-1:0]  pix_data,
    output logic              wr_en,
    output logic [14:0]       wr_addr,
    output logic [19:0]       wr_data,
    output logic              busy,
    output logic              frame_done,
    output logic              frame_err
);

    localparam int ADDR_W = 15;
    localparam int II_W   = 20;
    localparam int COL_W  = (II_WIDTH  > 1) ? $clog2(II_WIDTH)  : 1;
    localparam int ROW_W  = (II_HEIGHT > 1) ? $clog2(II_HEIGHT) : 1;

    localparam logic [COL_W-1:0] LAST_COL = COL_W'(II_WIDTH - 1);
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(II_HEIGHT - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    // Zero-extend a pixel to the integral word width.
    function automatic logic [II_W-1:0] pix_ext(input logic [PIX_W-1:0] p);
        return {{(II_W - PIX_W){1'b0}}, p};
    endfunction

    // Unsigned integral-word addition. For the default frame size the
    // largest possible sum (15 * 19200) fits in 20 bits, so no saturation.
    function automatic logic [II_W-1:0] ii_add(input logic [II_W-1:0] a,
                                               input logic [II_W-1:0] b);
        return a + b;
    endfunction

    // Control / position state
    state_t              state_q,   state_d;
    logic [COL_W-1:0]    col_q,     col_d;
    logic [ROW_W-1:0]    row_q,     row_d;
    logic [ADDR_W-1:0]   addr_q,    addr_d;
    logic [II_W-1:0]     row_acc_q, row_acc_d;

    // Registered write port
    logic                wr_en_q,   wr_en_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [II_W-1:0]     wr_data_q, wr_data_d;
    logic                done_q,    done_d;

    // One-row line buffer of integral values; entry II_WIDTH-1 holds the
    // value of the current column in the previous row.
    logic [II_W-1:0]     line_buf_q [II_WIDTH];

    // Per-pixel combinational terms
    logic                accept;
    logic [COL_W-1:0]    cur_col;
    logic [ROW_W-1:0]    cur_row;
    logic [ADDR_W-1:0]   cur_addr;
    logic [II_W-1:0]     above;
    logic [II_W-1:0]     row_sum;
    logic [II_W-1:0]     ii_new;

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        addr_d    = addr_q;
        row_acc_d = row_acc_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        done_d    = 1'b0;
        cur_col   = col_q;
        cur_row   = row_q;
        cur_addr  = addr_q;
        above     = '0;
        row_sum   = '0;
        ii_new    = '0;

        // In IDLE only a start-of-frame pixel is taken; in ACCUM every
        // valid pixel is taken.
        accept = pix_valid && (pix_sof || (state_q == ACCUM));

        // A sof pixel always lands at (0,0), also when it abandons a frame
        // in progress. Row 0 forces the previous-row term to zero, so stale
        // line-buffer contents are never used.
        if (pix_sof) begin
            cur_col  = '0;
            cur_row  = '0;
            cur_addr = '0;
        end

        above   = (cur_row == '0) ? '0 : line_buf_q[II_WIDTH-1];
        row_sum = (cur_col == '0) ? pix_ext(pix_data)
                                  : ii_add(row_acc_q, pix_ext(pix_data));
        ii_new  = ii_add(row_sum, above);

        if (accept) begin
            row_acc_d = row_sum;
            wr_en_d   = 1'b1;
            wr_addr_d = cur_addr;
            wr_data_d = ii_new;
            addr_d    = cur_addr + ADDR_W'(1);
            state_d   = ACCUM;
            if (cur_col == LAST_COL) begin
                col_d = '0;
                if (cur_row == LAST_ROW) begin
                    row_d   = '0;
                    addr_d  = '0;
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    row_d = cur_row + ROW_W'(1);
                end
            end else begin
                col_d = cur_col + COL_W'(1);
                row_d = cur_row;
            end
        end
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            state_q   <= IDLE;
            col_q     <= '0;
            row_q     <= '0;
            addr_q    <= '0;
            row_acc_q <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_q     <= col_d;
            row_q     <= row_d;
            addr_q    <= addr_d;
            row_acc_q <= row_acc_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
        end
    end

    // Line buffer is pure data: never read before it has been refilled,
    // so it carries no reset.
    always_ff @(posedge clk_vga) begin
        if (accept) begin
            line_buf_q[0] <= ii_new;
            for (int i = 1; i < II_WIDTH; i++) begin
                line_buf_q[i] <= line_buf_q[i-1];
            end
        end
    end

`ifdef II_BUILDER_ERR_EN
    logic err_q, err_d;

    // Any sof while in ACCUM means the previous frame never completed.
    always_comb begin
        err_d = err_q | (pix_valid && pix_sof && (state_q == ACCUM));
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign frame_err = err_q;
`else
    assign frame_err = 1'b0;
`endif

    assign wr_en      = wr_en_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign frame_done = done_q;
    // ACCUM is entered on the edge that takes the sof pixel and left on the
    // edge that produces the final write, matching the busy window.
    assign busy       = (state_q == ACCUM);

endmodule

// File: tb/tb_integral_image_builder.sv
module tb_integral_image_builder;

    localparam int FW = 160;
    localparam int FH = 120;
    localparam int SW = 16;
    localparam int SH = 12;
`ifdef II_BUILDER_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        pv_f, ps_f, pv_s, ps_s;
    logic [3:0]  pd_f, pd_s;
    logic        wr_en_f, busy_f, frame_done_f, frame_err_f;
    logic [14:0] wr_addr_f;
    logic [19:0] wr_data_f;
    logic        wr_en_s, busy_s, frame_done_s, frame_err_s;
    logic [14:0] wr_addr_s;
    logic [19:0] wr_data_s;

    integral_image_builder #(.II_WIDTH(FW), .II_HEIGHT(FH), .PIX_W(4)) dut_full (
        .clk_vga(clk), .rst(rst), .pix_valid(pv_f), .pix_sof(ps_f), .pix_data(pd_f),
        .wr_en(wr_en_f), .wr_addr(wr_addr_f), .wr_data(wr_data_f),
        .busy(busy_f), .frame_done(frame_done_f), .frame_err(frame_err_f));

    integral_image_builder #(.II_WIDTH(SW), .II_HEIGHT(SH), .PIX_W(4)) dut_small (
        .clk_vga(clk), .rst(rst), .pix_valid(pv_s), .pix_sof(ps_s), .pix_data(pd_s),
        .wr_en(wr_en_s), .wr_addr(wr_addr_s), .wr_data(wr_data_s),
        .busy(busy_s), .frame_done(frame_done_s), .frame_err(frame_err_s));

    int nchecks = 0;
    int nerr    = 0;
    int cyc     = 0;

    // Reference model: integral image by inclusion-exclusion on a 2-D array.
    int m_act [2];
    int m_c   [2];
    int m_r   [2];
    int m_err [2];
    int ii_m  [2][FH][FW];

    int cap_f [FW*FH];
    int cap_s [SW*SH];
    int wcnt  [2];
    int dcnt  [2];
    int daddr [2];

    typedef struct {
        int inst;
        int frame;
        int addr;
        int expv;
    } spot_t;
    spot_t spots [15];

    task automatic chk(input string name, input longint act, input longint exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [38:0] pack(input logic en, input logic [14:0] a,
                                         input logic [19:0] d, input logic dn,
                                         input logic b, input logic e);
        return {en, a, d, dn, b, e};
    endfunction

    task automatic mstep(input int k, input int W, input int H, input bit r,
                         input bit v, input bit s, input int d,
                         output logic [38:0] e, output bit full);
        int c, rw, val, a;
        bit en, dn;
        en = 0; dn = 0; a = 0; val = 0; full = 0;
        if (r) begin
            m_act[k] = 0; m_c[k] = 0; m_r[k] = 0; m_err[k] = 0;
            e = '0;
            full = 1;
            return;
        end
        if (v && (s || m_act[k] != 0)) begin
            if (s) begin
                if (m_act[k] != 0) m_err[k] = 1;
                m_c[k] = 0; m_r[k] = 0; m_act[k] = 1;
            end
            c  = m_c[k];
            rw = m_r[k];
            val = d;
            if (c > 0)            val += ii_m[k][rw][c-1];
            if (rw > 0)           val += ii_m[k][rw-1][c];
            if (c > 0 && rw > 0)  val -= ii_m[k][rw-1][c-1];
            ii_m[k][rw][c] = val;
            en = 1;
            a  = rw * W + c;
            if (c == W - 1) begin c = 0; rw++; end
            else c++;
            if (rw == H) begin m_act[k] = 0; dn = 1; c = 0; rw = 0; end
            m_c[k] = c;
            m_r[k] = rw;
        end
        full = en;
        e = {en, 15'(a), 20'(val), dn, (m_act[k] != 0), (ERR_EN && m_err[k] != 0)};
    endtask

    task automatic cycle(input bit r, input bit vf, input bit sf, input int df,
                         input bit vs, input bit ss, input int ds);
        logic [38:0] ef, es, af, as_;
        bit fullf, fulls;
        rst = r;
        pv_f = vf; ps_f = sf; pd_f = 4'(df);
        pv_s = vs; ps_s = ss; pd_s = 4'(ds);
        @(posedge clk);
        #1;
        cyc++;
        mstep(0, FW, FH, r, vf, sf, df, ef, fullf);
        mstep(1, SW, SH, r, vs, ss, ds, es, fulls);
        af  = pack(wr_en_f, wr_addr_f, wr_data_f, frame_done_f, busy_f, frame_err_f);
        as_ = pack(wr_en_s, wr_addr_s, wr_data_s, frame_done_s, busy_s, frame_err_s);
        if (!fullf) begin af[37:3] = '0; ef[37:3] = '0; end
        if (!fulls) begin as_[37:3] = '0; es[37:3] = '0; end
        chk($sformatf("full_out@%0d", cyc), af, ef);
        chk($sformatf("small_out@%0d", cyc), as_, es);
        if (wr_en_f === 1'b1) begin
            wcnt[0]++;
            if (int'(wr_addr_f) < FW*FH) cap_f[wr_addr_f] = int'(wr_data_f);
            if (frame_done_f === 1'b1) begin dcnt[0]++; daddr[0] = int'(wr_addr_f); end
        end
        if (wr_en_s === 1'b1) begin
            wcnt[1]++;
            if (int'(wr_addr_s) < SW*SH) cap_s[wr_addr_s] = int'(wr_data_s);
            if (frame_done_s === 1'b1) begin dcnt[1]++; daddr[1] = int'(wr_addr_s); end
        end
    endtask

    task automatic clear_counts();
        for (int i = 0; i < 2; i++) begin wcnt[i] = 0; dcnt[i] = 0; daddr[i] = -1; end
        for (int i = 0; i < FW*FH; i++) cap_f[i] = -1;
        for (int i = 0; i < SW*SH; i++) cap_s[i] = -1;
    endtask

    task automatic check_spots(input int frame);
        int act;
        for (int i = 0; i < 15; i++) begin
            if (spots[i].frame == frame) begin
                act = (spots[i].inst == 0) ? cap_f[spots[i].addr] : cap_s[spots[i].addr];
                chk($sformatf("spot f%0d addr %0d", frame, spots[i].addr), act, spots[i].expv);
            end
        end
    endtask

    task automatic small_ones(input int n, input bit sof_first);
        for (int i = 0; i < n; i++) cycle(0, 0, 0, 0, 1, sof_first && i == 0, 1);
    endtask

    initial begin
        // {instance, frame id, address, expected integral value}
        spots[0]  = '{0, 0, 0,     1};
        spots[1]  = '{0, 0, 159,   160};
        spots[2]  = '{0, 0, 160,   2};
        spots[3]  = '{0, 0, 161,   4};
        spots[4]  = '{0, 0, 4799,  4800};
        spots[5]  = '{0, 0, 19199, 19200};
        spots[6]  = '{0, 1, 0,     15};
        spots[7]  = '{0, 1, 159,   2400};
        spots[8]  = '{0, 1, 19199, 288000};
        spots[9]  = '{1, 2, 53,    7};
        spots[10] = '{1, 2, 52,    0};
        spots[11] = '{1, 2, 37,    0};
        spots[12] = '{1, 2, 54,    7};
        spots[13] = '{1, 2, 69,    7};
        spots[14] = '{1, 2, 191,   7};

        for (int k = 0; k < 2; k++) begin m_act[k] = 0; m_c[k] = 0; m_r[k] = 0; m_err[k] = 0; end
        clear_counts();

        // Reset state
        cycle(1, 0, 0, 0, 0, 0, 0);
        cycle(1, 1, 1, 5, 1, 1, 5);
        chk("reset wr_addr", wr_addr_f, 0);
        chk("reset wr_data", wr_data_f, 0);

        // All-ones full frame
        clear_counts();
        for (int i = 0; i < FW*FH; i++) cycle(0, 1, i == 0, 1, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check_spots(0);
        chk("ones writes", wcnt[0], FW*FH);
        chk("ones done count", dcnt[0], 1);
        chk("ones done addr", daddr[0], FW*FH-1);
        chk("ones busy after", busy_f, 0);

        // All-15 full frame
        clear_counts();
        for (int i = 0; i < FW*FH; i++) cycle(0, 1, i == 0, 15, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0, 0);
        check_spots(1);
        chk("f15 done count", dcnt[0], 1);
        chk("f15 busy after", busy_f, 0);

        // Random small frames with gaps and ignored idle pixels
        for (int f = 0; f < 3; f++) begin
            int sent;
            clear_counts();
            for (int i = 0; i < 5; i++) cycle(0, 0, 0, 0, 1, 0, $urandom_range(0, 15));
            sent = 0;
            while (sent < SW*SH) begin
                if ($urandom_range(0, 3) != 0) begin
                    cycle(0, 0, 0, 0, 1, sent == 0, $urandom_range(0, 15));
                    sent++;
                end else begin
                    cycle(0, 0, 0, 0, 0, 0, 0);
                end
            end
            for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, 0, $urandom_range(0, 15));
            chk($sformatf("rand%0d writes", f), wcnt[1], SW*SH);
            chk($sformatf("rand%0d done", f), dcnt[1], 1);
        end

        // Single pixel 7 at (5,3)
        clear_counts();
        for (int i = 0; i < SW*SH; i++)
            cycle(0, 0, 0, 0, 1, i == 0, (i % SW == 5 && i / SW == 3) ? 7 : 0);
        check_spots(2);

        // Valid toggling every cycle
        clear_counts();
        for (int i = 0; i < 2*SW*SH; i++)
            cycle(0, 0, 0, 0, (i % 2) == 0, i == 0, $urandom_range(0, 15));
        cycle(0, 0, 0, 0, 0, 0, 0);
        chk("toggle writes", wcnt[1], SW*SH);
        chk("toggle done", dcnt[1], 1);
        chk("toggle done addr", daddr[1], SW*SH-1);

        // sof mid-frame restarts at (0,0)
        clear_counts();
        small_ones(100, 1);
        cycle(0, 0, 0, 0, 1, 1, 1);
        chk("restart addr", wr_addr_s, 0);
        chk("restart data", wr_data_s, 1);
        chk("restart err", frame_err_s, ERR_EN);
        small_ones(SW*SH-1, 0);
        chk("restart done", dcnt[1], 1);
        small_ones(SW*SH, 1);
        chk("post-restart last", cap_s[SW*SH-1], SW*SH);
        chk("post-restart done", dcnt[1], 2);
        chk("err sticky", frame_err_s, ERR_EN);

        // Reset mid-frame
        clear_counts();
        small_ones(150, 1);
        cycle(1, 0, 0, 0, 1, 0, 1);
        chk("midreset wr_en", wr_en_s, 0);
        chk("midreset err", frame_err_s, 0);
        chk("midreset busy", busy_s, 0);
        small_ones(10, 0);
        chk("ignored after reset", wcnt[1], 150);
        small_ones(SW*SH, 1);
        chk("after reset addr17", cap_s[17], 4);
        chk("after reset last", cap_s[SW*SH-1], SW*SH);
        chk("after reset done", dcnt[1], 1);

        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
